collatz_engine: RTL and testbench

- Iterative Collatz sequence engine; parametrised successor to the single-step Collatz datapath.
- Accepts a start value over a start/busy/done handshake and iterates one step per cycle until the value reaches 1. An optional fast mode merges odd steps.
- Reports step count, peak value and a status code; aborts cleanly on arithmetic overflow or step-counter exhaustion.
- Sits behind the top-level pin wrapper, which maps `ui_in`/`uo_out` onto its ports.

---
 rtl/collatz_engine.sv | 132 +++++++++++++
 tb/tb_collatz_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/collatz_engine.sv
// Iterative Collatz engine: one step per RUN cycle, reports steps, peak and status.
// Optional macro COLLATZ_SHORTCUT_EN merges each odd step with the following halving.
module collatz_engine #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  start_val,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps,
    output logic [WIDTH-1:0]  peak,
    output logic [1:0]        status
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ZERO     = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    localparam logic [WIDTH-1:0] N_ONE   = WIDTH'(1);
    localparam logic [STEP_W:0]  ONE_INC = (STEP_W+1)'(1);
`ifdef COLLATZ_SHORTCUT_EN
    localparam logic [STEP_W:0]  ODD_INC = (STEP_W+1)'(2);
`else
    localparam logic [STEP_W:0]  ODD_INC = (STEP_W+1)'(1);
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   peak_q, peak_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [1:0]         status_q, status_d;
    logic               done_q, done_d;

    logic               is_odd;
    logic [WIDTH+1:0]   triple;
    logic               overflow;
    logic [STEP_W:0]    step_sum;

    function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // 3n+1 is formed two bits wider so overflow shows up in the top bits
    assign is_odd   = n_q[0];
    assign triple   = ({2'b00, n_q} << 1) + {2'b00, n_q} + (WIDTH+2)'(1);
    assign overflow = |triple[WIDTH+1:WIDTH];
    assign step_sum = {1'b0, steps_q} + (is_odd ? ODD_INC : ONE_INC);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        peak_d   = peak_q;
        steps_d  = steps_q;
        status_d = status_q;
        done_d   = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                steps_d  = '0;
                status_d = ST_OK;
                if (start_val == '0) begin
                    done_d   = 1'b1;
                    status_d = ST_ZERO;
                    peak_d   = '0;
                    n_d      = '0;
                end else begin
                    n_d     = start_val;
                    peak_d  = start_val;
                    state_d = S_RUN;
                end
            end
        end else begin
            // Abort checks come before any update so aborted runs keep pre-step values
            if (n_q == N_ONE) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                status_d = ST_OK;
            end else if (step_sum[STEP_W]) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                status_d = ST_TIMEOUT;
            end else if (is_odd && overflow) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                status_d = ST_OVERFLOW;
            end else if (is_odd) begin
                peak_d  = umax(peak_q, triple[WIDTH-1:0]);
                steps_d = step_sum[STEP_W-1:0];
`ifdef COLLATZ_SHORTCUT_EN
                n_d     = triple[WIDTH:1];
`else
                n_d     = triple[WIDTH-1:0];
`endif
            end else begin
                n_d     = n_q >> 1;
                steps_d = step_sum[STEP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            peak_q   <= '0;
            steps_q  <= '0;
            status_q <= ST_OK;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            peak_q   <= peak_d;
            steps_q  <= steps_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign steps  = steps_q;
    assign peak   = peak_q;
    assign status = status_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Self-checking bench for collatz_engine: vector table, hand sequences and random runs vs a model.
module tb_collatz_engine;

    localparam int W = 16;
`ifdef COLLATZ_SHORTCUT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start, start4;
    logic [W-1:0]  start_val, start_val4;
    logic          busy, done, busy4, done4;
    logic [7:0]    steps;
    logic [3:0]    steps4;
    logic [W-1:0]  peak, peak4;
    logic [1:0]    status, status4;

    int pass_cnt = 0;
    int total_cnt = 0;

    collatz_engine #(.WIDTH(W), .STEP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_val(start_val),
        .busy(busy), .done(done), .steps(steps), .peak(peak), .status(status)
    );

    collatz_engine #(.WIDTH(W), .STEP_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .start_val(start_val4),
        .busy(busy4), .done(done4), .steps(steps4), .peak(peak4), .status(status4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Collatz rules applied directly with integer arithmetic
    function automatic void model(input longint sv, input int sw,
                                  output longint st, output longint pk,
                                  output longint stat, output longint cyc);
        longint n, t, inc, iters;
        st = 0; pk = 0; stat = 0; cyc = 1;
        if (sv == 0) begin
            stat = 1;
            return;
        end
        n = sv; pk = sv; iters = 0;
        forever begin
            if (n == 1) break;
            inc = (n % 2 == 1 && FAST) ? 2 : 1;
            if (st + inc > (64'd1 << sw) - 1) begin stat = 3; break; end
            if (n % 2 == 1) begin
                t = 3 * n + 1;
                if (t > (64'd1 << W) - 1) begin stat = 2; break; end
                if (t > pk) pk = t;
                n = FAST ? t / 2 : t;
            end else begin
                n = n / 2;
            end
            st += inc;
            iters++;
        end
        cyc = iters + 2;
    endfunction

    // Runs one transaction; cyc_o is the cycle index (accept edge = k) where done is seen
    task automatic run(input bit which, input longint sv, input bit noise,
                       output longint cyc_o, output longint st_o,
                       output longint pk_o, output longint stat_o);
        int c;
        bit busy_ok;
        bit d;
        @(negedge clk);
        if (which) begin start4 = 1'b1; start_val4 = W'(sv); end
        else begin start = 1'b1; start_val = W'(sv); end
        @(posedge clk);
        #1;
        start = 1'b0; start4 = 1'b0;
        start_val = W'($urandom); start_val4 = W'($urandom);
        c = 1;
        busy_ok = 1'b1;
        forever begin
            d = which ? done4 : done;
            if (d) break;
            if (!(which ? busy4 : busy)) busy_ok = 1'b0;
            if (c > 1000) break;
            if (which) start4 = noise; else start = noise;
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0; start4 = 1'b0;
        if (c > 1000) chk("done_wait_bound", 0, 1);
        chk($sformatf("busy_during_run_%0d", sv), busy_ok, 1);
        chk($sformatf("busy_low_at_done_%0d", sv), which ? busy4 : busy, 0);
        cyc_o  = c;
        st_o   = which ? steps4 : steps;
        pk_o   = which ? peak4 : peak;
        stat_o = which ? status4 : status;
    endtask

    typedef struct {
        bit     which;
        longint sv;
        longint steps;
        longint peak;
        longint status;
        longint cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        longint c, s, p, st, ms, mp, mst, mc;
        rst = 1'b1; start = 1'b0; start4 = 1'b0; start_val = '0; start_val4 = '0;

        vecs[0] = '{0, 6,      8,   16,    0, FAST ? 8 : 10};
        vecs[1] = '{0, 1,      0,   1,     0, 2};
        vecs[2] = '{0, 0,      0,   0,     1, 1};
        vecs[3] = '{0, 65535,  0,   65535, 2, 2};
        vecs[4] = '{0, 27,     111, 9232,  0, FAST ? -1 : 113};
        vecs[5] = '{0, 7,      16,  52,    0, FAST ? -1 : 18};
        vecs[6] = '{1, 27,     15,  484,   3, FAST ? -1 : 17};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_steps", steps, 0);
        chk("reset_peak", peak, 0);
        chk("reset_status", status, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            model(vecs[i].sv, vecs[i].which ? 4 : 8, ms, mp, mst, mc);
            run(vecs[i].which, vecs[i].sv, 1'b0, c, s, p, st);
            chk($sformatf("vec%0d_steps", i), s, vecs[i].steps);
            chk($sformatf("vec%0d_peak", i), p, vecs[i].peak);
            chk($sformatf("vec%0d_status", i), st, vecs[i].status);
            chk($sformatf("vec%0d_cycle", i), c, (vecs[i].cyc < 0) ? mc : vecs[i].cyc);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_one_cycle", i), vecs[i].which ? done4 : done, 0);
            chk($sformatf("vec%0d_hold_steps", i), vecs[i].which ? steps4 : steps, vecs[i].steps);
            chk($sformatf("vec%0d_hold_status", i), vecs[i].which ? status4 : status, vecs[i].status);
        end

        // Back-to-back: second start lands in the cycle done is high, with start noise while busy
        run(1'b0, 9, 1'b1, c, s, p, st);
        model(9, 8, ms, mp, mst, mc);
        chk("noise_steps", s, ms);
        chk("noise_peak", p, mp);
        chk("noise_cycle", c, mc);
        run(1'b0, 3, 1'b1, c, s, p, st);
        chk("b2b_steps", s, 7);
        chk("b2b_peak", p, 16);
        chk("b2b_cycle", c, FAST ? 7 : 9);

        // Reset in the middle of a long run
        @(negedge clk);
        start = 1'b1; start_val = 16'd27;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_steps", steps, 0);
        chk("midrst_peak", peak, 0);
        chk("midrst_status", status, 0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 6, 1'b0, c, s, p, st);
        chk("after_rst_steps", s, 8);
        chk("after_rst_peak", p, 16);

        // Randomized runs against the model
        for (int r = 0; r < 30; r++) begin
            longint sv;
            bit which;
            which = (r % 5 == 4);
            case (r % 3)
                0: sv = $urandom_range(1, 300);
                1: sv = $urandom_range(1, 5000);
                default: sv = $urandom_range(0, 65535);
            endcase
            model(sv, which ? 4 : 8, ms, mp, mst, mc);
            run(which, sv, r[0], c, s, p, st);
            chk($sformatf("rnd%0d_steps_sv%0d", r, sv), s, ms);
            chk($sformatf("rnd%0d_peak_sv%0d", r, sv), p, mp);
            chk($sformatf("rnd%0d_status_sv%0d", r, sv), st, mst);
            chk($sformatf("rnd%0d_cycle_sv%0d", r, sv), c, mc);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
